serial_parity_checker: RTL and testbench

SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

---
 rtl/serial_parity_checker_pkg.sv | 32 +++
 rtl/serial_parity_checker_parity_acc.sv | 34 +++
 rtl/serial_parity_checker.sv | 111 +++++++++++
 tb/tb_serial_parity_checker.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_checker_pkg.sv
// Shared types and parity helpers for serial_parity_checker.
// Define ODD_PARITY_EN to build odd parity; the default build is even parity.
package serial_parity_checker_pkg;

    localparam int FRAME_LEN_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Reported parity for an accumulated XOR of the data bits.
    function automatic logic parity_out(input logic acc);
`ifdef ODD_PARITY_EN
        return ~acc;
`else
        return acc;
`endif
    endfunction

    // Mismatch between the accumulated data parity and the received parity bit.
    function automatic logic parity_err(input logic acc, input logic din);
`ifdef ODD_PARITY_EN
        return ~(acc ^ din);
`else
        return acc ^ din;
`endif
    endfunction

endpackage

// File: rtl/serial_parity_checker_parity_acc.sv
// One-bit XOR accumulator: clear has priority over enable.
// Synchronous active-low reset.
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic acc
);

    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = 1'b0;
        end else if (en) begin
            acc_d = acc_q ^ din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame parity checker: FRAME_LEN data bits then one parity bit, one-cycle result strobe.
// Optional macro ODD_PARITY_EN selects odd parity (see package helpers).
module serial_parity_checker
    import serial_parity_checker_pkg::*;
#(
    parameter int FRAME_LEN = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic START,
    input  logic DIN,
    input  logic DIN_VALID,
    output logic BUSY,
    output logic PARITY,
    output logic PARITY_VALID,
    output logic ERR
);

    localparam int FRAME_LEN_C = (FRAME_LEN < 2) ? 2 :
                                 (FRAME_LEN > FRAME_LEN_MAX) ? FRAME_LEN_MAX : FRAME_LEN;
    localparam int CNT_W = $clog2(FRAME_LEN_C);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN_C - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             acc_clr;
    logic             acc_en;
    logic             acc;
    logic             done;

    parity_acc u_parity_acc (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (acc_clr),
        .en    (acc_en),
        .din   (DIN),
        .acc   (acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    acc_clr = 1'b1;
                end
            end
            DATA: begin
                if (START) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    acc_clr = 1'b1;
                end else if (DIN_VALID) begin
                    acc_en = 1'b1;
                    // Counter parks on the last index instead of wrapping.
                    if (cnt_q == LAST_CNT) begin
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (START) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    acc_clr = 1'b1;
                end else if (DIN_VALID) begin
                    err_d   = parity_err(acc, DIN);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Results are gated so PARITY and ERR read 0 outside the DONE cycle.
    assign done         = (state_q == DONE);
    assign BUSY         = (state_q == DATA) || (state_q == CHECK);
    assign PARITY_VALID = done;
    assign PARITY       = done & parity_out(acc);
    assign ERR          = done & err_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Self-checking bench for serial_parity_checker (FRAME_LEN=8), scoreboard of expected results.
module tb_serial_parity_checker;

    localparam int FL = 8;

    logic CLK;
    logic RST_N;
    logic START;
    logic DIN;
    logic DIN_VALID;
    logic BUSY;
    logic PARITY;
    logic PARITY_VALID;
    logic ERR;

    typedef struct packed {
        logic par;
        logic err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   strobes = 0;

    serial_parity_checker #(.FRAME_LEN(FL)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .START        (START),
        .DIN          (DIN),
        .DIN_VALID    (DIN_VALID),
        .BUSY         (BUSY),
        .PARITY       (PARITY),
        .PARITY_VALID (PARITY_VALID),
        .ERR          (ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Counts strobes of the cycle just ending.
    always @(posedge CLK) begin
        if (PARITY_VALID === 1'b1) strobes++;
    end

    function automatic exp_t model(input logic [31:0] d, input logic pbit);
        logic a;
        exp_t e;
        a = 1'b0;
        for (int i = 0; i < FL; i++) a = a ^ d[i];
`ifdef ODD_PARITY_EN
        e.par = ~a;
        e.err = ~(a ^ pbit);
`else
        e.par = a;
        e.err = a ^ pbit;
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives START (with a junk valid bit that must be ignored), the data bits and the parity bit.
    task automatic send_frame(input logic [31:0] d, input logic pbit, input int maxgap);
        START = 1'b1;
        DIN = 1'b1;
        DIN_VALID = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i <= FL; i++) begin
            int g;
            g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
            DIN_VALID = 1'b0;
            repeat (g) step();
            DIN = (i == FL) ? pbit : d[i];
            DIN_VALID = 1'b1;
            step();
        end
        DIN_VALID = 1'b0;
        DIN = 1'b0;
        sb.push_back(model(d, pbit));
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        START = 1'b1;
        DIN = 1'b1;
        DIN_VALID = 1'b1;
        step();
        step();
        @(negedge CLK);
        vectors++;
        if ({BUSY, PARITY, PARITY_VALID, ERR} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want 0000", {BUSY, PARITY, PARITY_VALID, ERR});
        end
        RST_N = 1'b1;
        START = 1'b0;
        DIN_VALID = 1'b0;
        step();
        @(negedge CLK);
        vectors++;
        if (BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle busy got %b want 0", BUSY);
        end
    endtask

    task automatic test_frame(input string name, input logic [31:0] d, input logic pbit, input int maxgap);
        exp_t e;
        send_frame(d, pbit, maxgap);
        @(negedge CLK);
        vectors++;
        if (PARITY_VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_valid got %b want 1", name, PARITY_VALID);
        end
        e = sb.pop_front();
        vectors++;
        if ({PARITY, ERR} !== {e.par, e.err}) begin
            miscompares++;
            $display("FAIL %s_result parity/err got %b%b want %b%b", name, PARITY, ERR, e.par, e.err);
        end
        step();
        @(negedge CLK);
        vectors++;
        if ({BUSY, PARITY, PARITY_VALID, ERR} !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s_after got %b want 0000", name, {BUSY, PARITY, PARITY_VALID, ERR});
        end
    endtask

    task automatic test_gaps();
        logic [31:0] d;
        logic [8:0]  bits;
        exp_t e;
        int busy_bad;
        d = 32'h4D;
        bits = {1'b0, d[7:0]};
        busy_bad = 0;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i <= FL; i++) begin
            int g;
            g = $urandom_range(3, 1);
            DIN_VALID = 1'b0;
            DIN = ~bits[i];
            for (int k = 0; k < g; k++) begin
                step();
                if (BUSY !== 1'b1) busy_bad++;
            end
            DIN = bits[i];
            DIN_VALID = 1'b1;
            step();
            if (i < FL && BUSY !== 1'b1) busy_bad++;
        end
        DIN_VALID = 1'b0;
        sb.push_back(model(d, 1'b0));
        vectors++;
        if (busy_bad != 0) begin
            miscompares++;
            $display("FAIL gaps_busy got %0d low cycles want 0", busy_bad);
        end
        @(negedge CLK);
        vectors++;
        if (PARITY_VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL gaps_valid got %b want 1", PARITY_VALID);
        end
        e = sb.pop_front();
        vectors++;
        if ({PARITY, ERR} !== {e.par, e.err}) begin
            miscompares++;
            $display("FAIL gaps_result got %b%b want %b%b", PARITY, ERR, e.par, e.err);
        end
        step();
    endtask

    task automatic test_abort(input int nbits);
        int s0;
        exp_t e;
        logic [31:0] d;
        d = 32'h4D;
        s0 = strobes;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            DIN = (i < FL) ? d[i] : 1'b1;
            DIN_VALID = 1'b1;
            step();
        end
        DIN_VALID = 1'b0;
        send_frame(32'h07, 1'b1, 0);
        @(negedge CLK);
        e = sb.pop_front();
        vectors++;
        if ({PARITY_VALID, PARITY, ERR} !== {1'b1, e.par, e.err}) begin
            miscompares++;
            $display("FAIL abort%0d_result got %b want %b", nbits, {PARITY_VALID, PARITY, ERR}, {1'b1, e.par, e.err});
        end
        step();
        step();
        vectors++;
        if (strobes - s0 != 1) begin
            miscompares++;
            $display("FAIL abort%0d_strobes got %0d want 1", nbits, strobes - s0);
        end
    endtask

    task automatic test_reset_midframe();
        int s0;
        s0 = strobes;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            DIN = 1'b1;
            DIN_VALID = 1'b1;
            step();
        end
        RST_N = 1'b0;
        START = 1'b1;
        step();
        RST_N = 1'b1;
        START = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({BUSY, PARITY, PARITY_VALID, ERR} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstmid_outputs got %b want 0000", {BUSY, PARITY, PARITY_VALID, ERR});
        end
        DIN = 1'b0;
        DIN_VALID = 1'b1;
        step();
        DIN_VALID = 1'b0;
        repeat (3) step();
        vectors++;
        if (strobes != s0 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_nostrobe got %0d strobes busy %b want 0 strobes busy 0", strobes - s0, BUSY);
        end
    endtask

    task automatic test_start_in_done();
        exp_t e;
        send_frame(32'hA5, 1'b1, 0);
        START = 1'b1;
        @(negedge CLK);
        e = sb.pop_front();
        vectors++;
        if ({PARITY_VALID, PARITY, ERR} !== {1'b1, e.par, e.err}) begin
            miscompares++;
            $display("FAIL done_start_result got %b want %b", {PARITY_VALID, PARITY, ERR}, {1'b1, e.par, e.err});
        end
        step();
        START = 1'b0;
        @(negedge CLK);
        vectors++;
        if (BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL done_start_ignored busy got %b want 0", BUSY);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int s0;
        s0 = strobes;
        for (int n = 0; n < 12; n++) begin
            logic [31:0] d;
            logic        p;
            d = $urandom;
            p = 1'($urandom_range(1, 0));
            send_frame(d, p, (n % 3 == 0) ? 2 : 0);
            @(negedge CLK);
            e = sb.pop_front();
            vectors++;
            if ({PARITY_VALID, PARITY, ERR} !== {1'b1, e.par, e.err}) begin
                miscompares++;
                $display("FAIL b2b_%0d got %b want %b data %h", n, {PARITY_VALID, PARITY, ERR}, {1'b1, e.par, e.err}, d[7:0]);
            end
            step();
        end
        step();
        vectors++;
        if (strobes - s0 != 12) begin
            miscompares++;
            $display("FAIL b2b_strobes got %0d want 12", strobes - s0);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        START = 1'b0;
        DIN = 1'b0;
        DIN_VALID = 1'b0;
        test_reset();
        test_frame("even_ok", 32'h4D, 1'b0, 0);
        test_frame("mismatch", 32'h07, 1'b0, 0);
        test_frame("all_ones", 32'hFF, 1'b1, 0);
`ifdef ODD_PARITY_EN
        test_frame("odd_ok", 32'h4D, 1'b1, 0);
`endif
        test_gaps();
        test_abort(5);
        test_abort(FL);
        test_reset_midframe();
        test_start_in_done();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
